// File: rtl/booth2_mul_pipe_final_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : booth2_mul_pipe_final_adder
// Purpose  : Pipelined carry-propagate adder closing the Booth radix-4
//            multiplier datapath. Adds the redundant sum/carry vectors one
//            SEG_WID segment per stage, with the carry between segments
//            registered. Operands are skewed in and sums deskewed out so
//            each operation leaves as one aligned word. valid/ready on both
//            sides.
// Option   : BOOTH2_MUL_ADDER_OVF_EN adds ovf_o (signed overflow flag).
// Revision : 1.0 - initial release
// ============================================================================

// 4-bit carry-look-ahead adder used as the building block of every segment.
module booth2_mul_pipe_final_adder_cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g    = a_i & b_i;
    assign w_p    = a_i ^ b_i;
    assign w_c[0] = c_i;
    assign w_c[1] = w_g[0] | (w_p[0] & c_i);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_i);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_i);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_i);
    assign s_o    = w_p ^ w_c[3:0];
    assign c_o    = w_c[4];
endmodule

module booth2_mul_pipe_final_adder #(
    parameter int DATA_WID = 64,
    parameter int SEG_WID  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                val_i,
    output logic                rdy_o,
    input  logic [DATA_WID-1:0] ai,
    input  logic [DATA_WID-1:0] bi,
    input  logic                cin,
    output logic                val_o,
    input  logic                rdy_i,
    output logic [DATA_WID-1:0] so,
    output logic                cout
`ifdef BOOTH2_MUL_ADDER_OVF_EN
    ,
    output logic                ovf_o
`endif
);
    localparam int STG_NUM = DATA_WID / SEG_WID;
    localparam int NIB_NUM = SEG_WID / 4;

    logic                w_en;
    logic [STG_NUM-1:0]  val_q;
    logic [STG_NUM:0]    w_carry;   // [0] = cin, [k+1] = registered carry of stage k
    logic [DATA_WID-1:0] w_so;
`ifdef BOOTH2_MUL_ADDER_OVF_EN
    logic                w_ovf;
`endif

    // The whole pipe advances together: only a held, unaccepted result stalls it.
    assign val_o    = val_q[STG_NUM-1];
    assign w_en     = ~val_o | rdy_i;
    assign rdy_o    = w_en;
    assign w_carry[0] = cin;

    // Valid shift register; a bubble on an advance enters as 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
        end else if (w_en) begin
            val_q[0] <= val_i;
            for (int i = 1; i < STG_NUM; i++) begin
                val_q[i] <= val_q[i-1];
            end
        end
    end

    for (genvar k = 0; k < STG_NUM; k++) begin : g_stage
        localparam int DSK = STG_NUM - 1 - k;

        logic [SEG_WID-1:0] w_a;
        logic [SEG_WID-1:0] w_b;
        logic [SEG_WID-1:0] sum_d;
        logic [NIB_NUM:0]   w_nc;
        logic [SEG_WID-1:0] sum_q;
        logic               carry_q;

        if (k == 0) begin : g_in0
            assign w_a = ai[SEG_WID-1:0];
            assign w_b = bi[SEG_WID-1:0];
        end else begin : g_skew
            logic [SEG_WID-1:0] a_skew_q [k];
            logic [SEG_WID-1:0] b_skew_q [k];

            // Delay segment k by k stages so it meets the carry from stage k-1.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < k; i++) begin
                        a_skew_q[i] <= '0;
                        b_skew_q[i] <= '0;
                    end
                end else if (w_en) begin
                    a_skew_q[0] <= ai[k*SEG_WID +: SEG_WID];
                    b_skew_q[0] <= bi[k*SEG_WID +: SEG_WID];
                    for (int i = 1; i < k; i++) begin
                        a_skew_q[i] <= a_skew_q[i-1];
                        b_skew_q[i] <= b_skew_q[i-1];
                    end
                end
            end

            assign w_a = a_skew_q[k-1];
            assign w_b = b_skew_q[k-1];
        end

        // Segment adder: nibble CLAs rippling carry from low to high nibble.
        assign w_nc[0] = w_carry[k];
        for (genvar j = 0; j < NIB_NUM; j++) begin : g_nib
            booth2_mul_pipe_final_adder_cla4 u_cla (
                .a_i (w_a[4*j +: 4]),
                .b_i (w_b[4*j +: 4]),
                .c_i (w_nc[j]),
                .s_o (sum_d[4*j +: 4]),
                .c_o (w_nc[j+1])
            );
        end

        // Stage register: segment sum and the carry handed to the next stage.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (w_en) begin
                sum_q   <= sum_d;
                carry_q <= w_nc[NIB_NUM];
            end
        end

        assign w_carry[k+1] = carry_q;

        if (DSK == 0) begin : g_nodsk
            assign w_so[k*SEG_WID +: SEG_WID] = sum_q;
        end else begin : g_dsk
            logic [SEG_WID-1:0] dsk_q [DSK];

            // Hold early segment sums until the top segment of the same operation is done.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DSK; i++) begin
                        dsk_q[i] <= '0;
                    end
                end else if (w_en) begin
                    dsk_q[0] <= sum_q;
                    for (int i = 1; i < DSK; i++) begin
                        dsk_q[i] <= dsk_q[i-1];
                    end
                end
            end

            assign w_so[k*SEG_WID +: SEG_WID] = dsk_q[DSK-1];
        end

`ifdef BOOTH2_MUL_ADDER_OVF_EN
        if (k == STG_NUM - 1) begin : g_ovf
            logic ovf_q;

            // Signed overflow: operand MSBs agree but the sum MSB differs.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (w_en) begin
                    ovf_q <= (w_a[SEG_WID-1] == w_b[SEG_WID-1]) &&
                             (sum_d[SEG_WID-1] != w_a[SEG_WID-1]);
                end
            end

            assign w_ovf = ovf_q;
        end
`endif
    end

    assign so   = w_so;
    assign cout = w_carry[STG_NUM];
`ifdef BOOTH2_MUL_ADDER_OVF_EN
    assign ovf_o = w_ovf;
`endif

endmodule
`default_nettype wire

// File: doc/booth2_mul_pipe_final_adder.md
Name: booth2_mul_pipe_final_adder

Overview:
- Pipelined carry-propagate adder that closes the Booth radix-4 multiplier datapath.
- Consumes the redundant sum/carry vectors from the partial-product compression tree and produces the final binary product.
- Splits the operand into segments, one segment per pipeline stage; each segment is a ripple of 4-bit carry-look-ahead adder instances.
- Inter-segment carry is registered; the pipe moves under a valid/ready handshake on both sides.

Parameters:
- DATA_WID, 64, operand and result width in bits; must be a multiple of SEG_WID.
- SEG_WID, 16, bits added per pipeline stage; must be a multiple of 4 (one 4-bit CLA per nibble).
- STG_NUM, DATA_WID/SEG_WID (derived localparam, not user-set), number of pipeline stages.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- val_i  input  1  input operands valid.
- rdy_o  output  1  block can accept an input this cycle.
- ai  input  DATA_WID  sum vector from compression tree.
- bi  input  DATA_WID  carry vector from compression tree (already shifted by the tree).
- cin  input  1  carry into bit 0.
- val_o  output  1  result valid.
- rdy_i  input  1  downstream accepts the result.
- so  output  DATA_WID  ai+bi+cin, modulo 2^DATA_WID.
- cout  output  1  carry out of bit DATA_WID-1.

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits 0; all data, carry and skew registers 0. Outputs: val_o=0, so=0, cout=0, rdy_o=1 once rst is low.
- Pipeline advance: en = !val_o | rdy_i. rdy_o = en.
- Input transfer occurs when val_i & rdy_o. Output transfer occurs when val_o & rdy_i.
- When en=0, every stage register holds, including so, cout and val_o.
- Stage k (0..STG_NUM-1):
  - Adds segment k of the operands plus the registered carry from stage k-1 (stage 0 uses cin).
  - Registers the segment sum and the segment carry-out.
  - Within a stage, SEG_WID/4 CLA instances ripple cout into cin.
- Input skew: segment k of ai/bi enters through k register stages, so it meets its carry in stage k.
- Output deskew: the sum of segment k is delayed by STG_NUM-1-k stages, so all segments of one operation appear together.
- Skew and deskew registers advance only with en.
- Valid pipe: one valid bit per stage, shifting with en. A bubble (val_i=0 on an advance) shifts in as valid=0. Data registers behind an invalid bit may update but are don't-care.
- Latency: an input accepted at edge N gives val_o=1 after edge N+STG_NUM-1, i.e. STG_NUM cycles with no back-pressure.
- Throughput: one operation per cycle when rdy_i is held high.
- Ordering: results leave in acceptance order. No drop and no duplication under any val_i/rdy_i pattern.
- Simultaneous input and output transfer in the same cycle is legal; the full pipe keeps streaming.
- Back-pressure while full: rdy_o drops combinationally with rdy_i. Sampling val_i while rdy_o=0 has no effect.
- cout is the carry out of the last segment, aligned with so.
- Reset asserted mid-operation: all in-flight operations are discarded immediately; the next accepted input restarts at full latency.

Optional Feature:
- Macro: BOOTH2_MUL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf_o (1 bit), aligned with so and val_o.
  - ovf_o = signed two's-complement overflow of ai+bi+cin: operand MSBs equal and sum MSB different from them.
  - Operand MSBs travel through the skew registers with the top segment.
  - ovf_o resets to 0 and holds when en=0.
- Undefined: no ovf_o port and no extra registers. so, cout and timing are identical in both builds.

Test Plan:
- Reset: assert rst mid-stream with val_i=1 -> val_o=0, so=0, cout=0 asynchronously. After release, the first result appears exactly STG_NUM=4 cycles after acceptance.
- Full carry ripple: ai=64'hFFFF_FFFF_FFFF_FFFF, bi=0, cin=1 -> after 4 cycles so=0, cout=1.
- Full carry ripple, second case: ai=64'h0000_0000_FFFF_FFFF, bi=64'h1, cin=0 -> so=64'h0000_0001_0000_0000, cout=0.
- Streaming: 8 back-to-back random operands, rdy_i=1 -> 8 consecutive val_o cycles starting at cycle 4, results in order, each equal to the reference sum.
- Back-pressure: pipe full, rdy_i=0 for 3 cycles -> rdy_o=0; val_o, so and cout stable. After rdy_i returns to 1, remaining results drain in order with no loss.
- Bubbles: val_i pattern 1,0,1,1,0 -> val_o pattern 1,0,1,1,0 delayed by 4 cycles.
- With BOOTH2_MUL_ADDER_OVF_EN: ai=64'h7FFF_FFFF_FFFF_FFFF, bi=0, cin=1 -> so=64'h8000_0000_0000_0000, ovf_o=1, cout=0.
- With BOOTH2_MUL_ADDER_OVF_EN: ai=64'hFFFF_FFFF_FFFF_FFFF, bi=64'h1, cin=0 -> ovf_o=0.
